// File: rtl/sum_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sum_bit_serializer
// Description : Captures a DATA_W-bit sum plus carry and plays it out one bit
//               per BIT_PERIOD clocks on a single pin. The frame is a start
//               marker, the data bits LSB first with the carry last, an
//               optional even-parity bit, and a stop bit.
//               Optional macro: SERIAL_PARITY_EN (adds the PARITY bit).
// Revision    : 1.0 - initial release
// ============================================================================
module sum_bit_serializer #(
    parameter int DATA_W     = 32,
    parameter int BIT_PERIOD = 1251
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_carry,
    output logic              led,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(BIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W:0]   sh_q, sh_d;
    logic              led_q, led_d;
    logic              done_q, done_d;
    logic              w_period_end;
`ifdef SERIAL_PARITY_EN
    logic              par_q, par_d;
`endif

    assign w_period_end = (cnt_q == c_last_cnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
`ifdef SERIAL_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = w_period_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (in_valid) begin
                    state_d = S_START;
                    sh_d    = {in_carry, in_data};
`ifdef SERIAL_PARITY_EN
                    par_d   = ^{in_carry, in_data};
`endif
                end
            end
            S_START: begin
                if (w_period_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (w_period_end) begin
                    sh_d = sh_q >> 1;
                    if (idx_q == c_last_idx) begin
`ifdef SERIAL_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef SERIAL_PARITY_EN
            S_PARITY: begin
                if (w_period_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_period_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output decode uses the next state so led/done are registered yet
        // line up with the state they belong to.
        led_d = 1'b0;
        case (state_d)
            S_START:  led_d = 1'b1;
            S_DATA:   led_d = sh_d[0];
`ifdef SERIAL_PARITY_EN
            S_PARITY: led_d = par_d;
`endif
            default:  led_d = 1'b0;
        endcase
        done_d = (state_d == S_STOP) && (cnt_d == c_last_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            led_q   <= led_d;
            done_q  <= done_d;
`ifdef SERIAL_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign led      = led_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);
    assign in_ready = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sum_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_bit_serializer
// Description : Self-checking bench for sum_bit_serializer at BIT_PERIOD=4
//               and BIT_PERIOD=1 against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_bit_serializer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst4_n, rst1_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_carry;
    logic          led4, busy4, done4, rdy4;
    logic          led1, busy1, done1, rdy1;
    logic          sel1;
    logic          led, busy, done, rdy;

    int n_pass  = 0;
    int n_total = 0;
    int cur_p   = 4;
    bit exp_bits[$];

    always #5 clk = ~clk;

    sum_bit_serializer #(.DATA_W(DW), .BIT_PERIOD(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .in_carry(in_carry), .led(led4), .busy(busy4), .done(done4)
    );

    sum_bit_serializer #(.DATA_W(DW), .BIT_PERIOD(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_carry(in_carry), .led(led1), .busy(busy1), .done(done1)
    );

    assign led  = sel1 ? led1  : led4;
    assign busy = sel1 ? busy1 : busy4;
    assign done = sel1 ? done1 : done4;
    assign rdy  = sel1 ? rdy1  : rdy4;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (P=%0d) t=%0t observed=%b expected=%b", tag, cur_p, $time, obs, exp);
    endtask

    // Frame as a list of bit values: start, word LSB first, carry, parity, stop.
    function automatic void build(input logic [DW-1:0] d, input logic c);
        int ones;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b1);
        for (int i = 0; i < DW; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        exp_bits.push_back(c);
        ones += int'(c);
`ifdef SERIAL_PARITY_EN
        exp_bits.push_back(bit'(ones % 2));
`endif
        exp_bits.push_back(1'b0);
    endfunction

    task automatic set_rst(input logic v);
        if (cur_p == 1) rst1_n = v;
        else            rst4_n = v;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_led"},   led,  1'b0);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_done"},  done, 1'b0);
        chk({tag, "_ready"}, rdy,  1'b1);
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle following the frame.
    task automatic frame(input logic [DW-1:0] d, input logic c, input bit hold, input int glitch_k);
        int fl;
        build(d, c);
        fl = exp_bits.size() * cur_p;
        in_valid = 1'b1;
        in_data  = d;
        in_carry = c;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        for (int k = 0; k < fl; k++) begin
            chk("frame_led",   led,  exp_bits[k / cur_p]);
            chk("frame_busy",  busy, 1'b1);
            chk("frame_ready", rdy,  1'b0);
            chk("frame_done",  done, k == fl - 1);
            if (glitch_k >= 0 && k == glitch_k) begin
                in_valid = 1'b1;
                in_data  = '1;
                in_carry = 1'b1;
            end else if (glitch_k >= 0 && k == glitch_k + 1) begin
                in_valid = 1'b0;
                in_data  = d;
                in_carry = c;
            end
            @(negedge clk);
        end
        chk("post_idle_busy",  busy, 1'b0);
        chk("post_idle_ready", rdy,  1'b1);
        chk("post_idle_led",   led,  1'b0);
        chk("post_idle_done",  done, 1'b0);
    endtask

    task automatic reset_mid(input logic [DW-1:0] d, input logic c);
        build(d, c);
        in_valid = 1'b1;
        in_data  = d;
        in_carry = c;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (cur_p * 11) @(negedge clk);
        chk("mid_bit10_led", led, exp_bits[11]);
        chk("mid_busy",      busy, 1'b1);
        #2;
        set_rst(1'b0);
        #1;
        chk_idle("async_rst");
        repeat (2) @(negedge clk);
        set_rst(1'b1);
        repeat (cur_p * 40) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 1'b0);
            chk("stay_idle_busy",    busy, 1'b0);
        end
        frame(~d, ~c, 1'b0, -1);
    endtask

    initial begin
        sel1     = 1'b0;
        cur_p    = 4;
        rst4_n   = 1'b0;
        rst1_n   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_carry = 1'b0;
        #12;
        chk_idle("reset4");

        @(negedge clk);
        rst4_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("idle4");
        end

        frame(32'h34D51531, 1'b1, 1'b0, -1);
        frame(32'h34D51531, 1'b1, 1'b0, 50);
        frame(32'h7F7DF7D7, 1'b0, 1'b1, -1);
        frame(32'h7F7DF7D7, 1'b0, 1'b1, -1);
        in_valid = 1'b0;
        @(negedge clk);
        chk_idle("after_b2b4");
        reset_mid(32'h34D51531, 1'b1);
        repeat (3) frame($urandom, 1'($urandom_range(0, 1)), 1'b0, -1);

        rst4_n = 1'b0;
        sel1   = 1'b1;
        cur_p  = 1;
        #1;
        chk_idle("reset1");
        @(negedge clk);
        rst1_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle("idle1");
        end
        frame(32'h34D51531, 1'b1, 1'b0, -1);
        frame(32'h34D51531, 1'b1, 1'b0, 10);
        frame(32'h7F7DF7D7, 1'b1, 1'b1, -1);
        frame(32'h7F7DF7D7, 1'b1, 1'b1, -1);
        in_valid = 1'b0;
        @(negedge clk);
        chk_idle("after_b2b1");
        reset_mid(32'h0F0F_5A5A, 1'b0);
        repeat (4) frame($urandom, 1'($urandom_range(0, 1)), 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
